xm_mem_stage: RTL and testbench
===============================

Name: xm_mem_stage

Overview:
- Execute→memory pipeline latch plus memory-access sequencer for the 5-stage core.
- Captures the X-stage instruction, ALU result and store data. Issues the data-memory request for sw (opcode 00111) and lw (opcode 01000).
- Stalls the upstream pipeline while memory is not ready, then hands a completed instruction and result to the M/W writeback latch.
- Replaces fixed single-cycle dmem access with a ready-handshake so slower memories (sprite/stage RAM) can share the port.

Parameters:
- DATA_WIDTH, 32, width of ALU result, store data and load data.
- ADDR_WIDTH, 12, dmem address width; taken from the low bits of the ALU result.
- MAX_WAIT, 15, maximum wait cycles for dmem_ready before the access is aborted (must be ≥1).

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- instruction_X  input  32  instruction leaving execute.
- aluResult_X  input  DATA_WIDTH  ALU result / effective address from execute.
- storeData_X  input  DATA_WIDTH  rd value to be stored by sw.
- flush_X  input  1  squash the incoming X instruction (load nop into M).
- stall_M  output  1  hold fetch/decode/execute latches this cycle.
- dmem_req  output  1  memory access request.
- dmem_WE  output  1  write enable; high only with dmem_req for sw.
- dmem_addr  output  ADDR_WIDTH  aluResult_M[ADDR_WIDTH-1:0].
- dmem_wdata  output  DATA_WIDTH  storeData_M.
- dmem_ready  input  1  memory completes the access this cycle; rdata valid when high.
- dmem_rdata  input  DATA_WIDTH  load data.
- instruction_W  output  32  instruction in M/W latch.
- data_W  output  DATA_WIDTH  writeback data.
- timeout_W  output  1  instruction in W was aborted by wait timeout.

Behaviour:
- Reset: M and W registers = 0 (nop), state = RUN, wait counter = 0. All outputs 0.
- Reset is asynchronous. Asserting it mid-WAIT drops dmem_req and stall_M immediately, and the pending access is discarded.
- Opcode decode: opM = instruction_M[31:27]; memop = (opM==7)|(opM==8).
- M register load:
  - When stall_M=0, each rising edge loads the X inputs.
  - When flush_X=1, it loads instruction 0 and data 0 instead.
  - When stall_M=1, M holds and flush_X is ignored.
- dmem_req = memop while in RUN or WAIT.
- stall_M = memop & ~dmem_ready & ~abort, where abort = (state==WAIT) & (cnt==MAX_WAIT) (combinational).
- State RUN:
  - memop & dmem_ready → completes; zero-wait, 1-cycle latency M→W.
  - memop & ~dmem_ready → WAIT, cnt ← 1.
  - Otherwise the instruction passes straight to W.
- State WAIT:
  - dmem_ready → completes; → RUN, cnt ← 0.
  - abort → → RUN, cnt ← 0.
  - Otherwise cnt ← cnt+1.
- W latch on complete or pass-through:
  - instruction_W ← instruction_M.
  - data_W ← dmem_rdata if opM==8, else aluResult_M.
  - timeout_W ← 0.
- W latch on abort: instruction_W ← instruction_M, data_W ← 0, timeout_W ← 1.
- W latch on stalled cycles: loads a bubble (instruction 0, data 0, timeout 0), so no duplicate writeback.
- dmem_ready while memop=0: ignored.
- dmem_WE = dmem_req & (opM==7); it stays high across every WAIT cycle of a store.
- Counter width is clog2(MAX_WAIT+1) and never wraps past MAX_WAIT.

Decomposition:
- Shared package (processor constants):
  - Opcode constants OP_RTYPE=0, OP_JAL=3, OP_ADDI=5, OP_SW=7, OP_LW=8, OP_SETX=21.
  - NOP instruction = 32'b0.
  - State encoding RUN/WAIT.
- One natural sub-module: mem_wait_counter (load/increment/clear, terminal-count flag at MAX_WAIT).
- M and W registers reuse the existing DFF register cells with enable.

Test Plan:
- add (op 0), aluResult_X=0x2A → no dmem_req, next edge instruction_W=add, data_W=0x2A, stall_M never high.
- lw, aluResult_X=0x10, dmem_ready=1 same cycle, rdata=0xDEAD → dmem_addr=0x010, dmem_WE=0, no stall, data_W=0xDEAD one edge later.
- sw, addr 0x20, storeData 0x55, ready after 3 cycles → dmem_req=dmem_WE=1 for 4 cycles, stall_M=1 for 3, W shows 3 bubbles then sw, M inputs held.
- lw with dmem_ready held 0, MAX_WAIT=15 → stall released on the 16th request cycle, timeout_W=1, data_W=0, state back to RUN.
- flush_X=1 with lw on X while not stalled → M=nop, no dmem_req. Repeat during a stall → flush ignored, M keeps the original lw.
- reset asserted mid-WAIT → dmem_req, stall_M and all outputs 0 immediately; after release a fresh add passes with 1-cycle latency.

Source files
------------

// File: rtl/xm_mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// xm_mem_stage_pkg
// Shared processor constants for the X->M->W memory stage:
//   - 5-bit opcode values (instruction[31:27])
//   - canonical NOP instruction
//   - memory sequencer state encoding
//   - opcode helpers used by the stage and its sub-blocks
// -----------------------------------------------------------------------------
package xm_mem_stage_pkg;

    localparam logic [4:0] OP_RTYPE = 5'd0;
    localparam logic [4:0] OP_JAL   = 5'd3;
    localparam logic [4:0] OP_ADDI  = 5'd5;
    localparam logic [4:0] OP_SW    = 5'd7;
    localparam logic [4:0] OP_LW    = 5'd8;
    localparam logic [4:0] OP_SETX  = 5'd21;

    localparam logic [31:0] NOP_INSTR = 32'b0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[31:27];
    endfunction

    function automatic logic is_memop(input logic [4:0] op);
        return (op == OP_SW) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/xm_mem_stage_if.sv
// -----------------------------------------------------------------------------
// xm_mem_stage_if
// Data-memory port with a ready handshake, shared by the core's memory stage
// and slower memories (sprite/stage RAM).
//   dmem_req   : access request (held until dmem_ready or abort)
//   dmem_WE    : write enable, only together with dmem_req for stores
//   dmem_addr  : word address
//   dmem_wdata : store data
//   dmem_ready : memory completes the access this cycle
//   dmem_rdata : load data, valid while dmem_ready is high
// Modports: master = requester (memory stage), slave = memory.
// -----------------------------------------------------------------------------
interface xm_mem_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  dmem_req;
    logic                  dmem_WE;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic                  dmem_ready;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_WE,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_WE,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/xm_mem_stage_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// Counts cycles spent waiting for dmem_ready.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   load         : start a wait (count <- 1)
//   inc          : one more wait cycle (saturates at MAX_WAIT, never wraps)
//   clr          : wait finished (count <- 0)
//   tc           : count has reached MAX_WAIT
// Priority: clr > load > inc.
// -----------------------------------------------------------------------------
module mem_wait_counter #(
    parameter int MAX_WAIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic inc,
    input  logic clr,
    output logic tc
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (inc && (cnt != TC_VAL)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/xm_mem_stage.sv
// -----------------------------------------------------------------------------
// xm_mem_stage
// Execute->memory pipeline latch plus data-memory access sequencer.
// Captures the X-stage instruction, ALU result and store data into M, issues a
// ready-handshaked dmem access for sw/lw, stalls upstream while the memory is
// not ready, and hands the finished instruction/result to the M/W latch.
// An access that waits MAX_WAIT cycles in WAIT is aborted and flagged.
// Ports:
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   instruction_X    : instruction leaving execute
//   aluResult_X      : ALU result / effective address
//   storeData_X      : value stored by sw
//   flush_X          : squash incoming X instruction (ignored while stalled)
//   stall_M          : hold fetch/decode/execute latches this cycle
//   dmem             : data-memory port (master side)
//   instruction_W    : instruction in the M/W latch
//   data_W           : writeback data (load data or ALU result)
//   timeout_W        : instruction in W was aborted by wait timeout
// -----------------------------------------------------------------------------
module xm_mem_stage
    import xm_mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instruction_X,
    input  logic [DATA_WIDTH-1:0] aluResult_X,
    input  logic [DATA_WIDTH-1:0] storeData_X,
    input  logic                  flush_X,
    output logic                  stall_M,
    xm_mem_stage_if.master        dmem,
    output logic [31:0]           instruction_W,
    output logic [DATA_WIDTH-1:0] data_W,
    output logic                  timeout_W
);

    logic [31:0]           instruction_M;
    logic [DATA_WIDTH-1:0] aluResult_M;
    logic [DATA_WIDTH-1:0] storeData_M;

    mem_state_t state, state_nxt;

    logic [4:0]            opM;
    logic                  memop;
    logic                  wait_tc;
    logic                  abort;
    logic                  cnt_load;
    logic                  cnt_inc;
    logic                  cnt_clr;
    logic [DATA_WIDTH-1:0] result_M;

    logic [31:0]           instruction_W_nxt;
    logic [DATA_WIDTH-1:0] data_W_nxt;
    logic                  timeout_W_nxt;

    assign opM      = opcode_of(instruction_M);
    assign memop    = is_memop(opM);
    assign abort    = (state == ST_WAIT) && wait_tc;
    assign stall_M  = memop && !dmem.dmem_ready && !abort;
    assign result_M = (opM == OP_LW) ? dmem.dmem_rdata : aluResult_M;

    assign dmem.dmem_req   = memop;
    assign dmem.dmem_WE    = memop && (opM == OP_SW);
    assign dmem.dmem_addr  = aluResult_M[ADDR_WIDTH-1:0];
    assign dmem.dmem_wdata = storeData_M;

    mem_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .tc    (wait_tc)
    );

    // ---- X -> M latch: holds while stalled, flush only honoured when moving
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instruction_M <= NOP_INSTR;
            aluResult_M   <= '0;
            storeData_M   <= '0;
        end else if (!stall_M) begin
            if (flush_X) begin
                instruction_M <= NOP_INSTR;
                aluResult_M   <= '0;
                storeData_M   <= '0;
            end else begin
                instruction_M <= instruction_X;
                aluResult_M   <= aluResult_X;
                storeData_M   <= storeData_X;
            end
        end
    end

    // ---- sequencer state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- sequencer next state and W-latch contents
    // W receives a bubble by default, so a stalled instruction is written
    // back exactly once: on the cycle it completes or aborts.
    always_comb begin
        state_nxt         = state;
        cnt_load          = 1'b0;
        cnt_inc           = 1'b0;
        cnt_clr           = 1'b0;
        instruction_W_nxt = NOP_INSTR;
        data_W_nxt        = '0;
        timeout_W_nxt     = 1'b0;

        case (state)
            ST_RUN: begin
                if (memop && !dmem.dmem_ready) begin
                    state_nxt = ST_WAIT;
                    cnt_load  = 1'b1;
                end else begin
                    instruction_W_nxt = instruction_M;
                    data_W_nxt        = result_M;
                end
            end
            ST_WAIT: begin
                // ready wins over abort if both land on the same cycle
                if (dmem.dmem_ready || !memop) begin
                    state_nxt         = ST_RUN;
                    cnt_clr           = 1'b1;
                    instruction_W_nxt = instruction_M;
                    data_W_nxt        = result_M;
                end else if (abort) begin
                    state_nxt         = ST_RUN;
                    cnt_clr           = 1'b1;
                    instruction_W_nxt = instruction_M;
                    timeout_W_nxt     = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    // ---- M -> W latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instruction_W <= NOP_INSTR;
            data_W        <= '0;
            timeout_W     <= 1'b0;
        end else begin
            instruction_W <= instruction_W_nxt;
            data_W        <= data_W_nxt;
            timeout_W     <= timeout_W_nxt;
        end
    end

endmodule

// File: tb/tb_xm_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_xm_mem_stage
// Directed bench for xm_mem_stage with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled 2 units later, registered outputs right after the edge.
// -----------------------------------------------------------------------------
module tb_xm_mem_stage;
    import xm_mem_stage_pkg::*;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MW = 15;

    localparam logic [31:0] I_ADD = {OP_RTYPE, 27'h0001234};
    localparam logic [31:0] I_LW  = {OP_LW,    27'h0000010};
    localparam logic [31:0] I_SW  = {OP_SW,    27'h0000020};

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   instruction_X = '0;
    logic [DW-1:0] aluResult_X = '0;
    logic [DW-1:0] storeData_X = '0;
    logic          flush_X = 1'b0;
    logic          stall_M;
    logic [31:0]   instruction_W;
    logic [DW-1:0] data_W;
    logic          timeout_W;

    int n_checks = 0;
    int n_errors = 0;

    xm_mem_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dmem_bus ();

    xm_mem_stage #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_WAIT   (MW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .instruction_X (instruction_X),
        .aluResult_X   (aluResult_X),
        .storeData_X   (storeData_X),
        .flush_X       (flush_X),
        .stall_M       (stall_M),
        .dmem          (dmem_bus),
        .instruction_W (instruction_W),
        .data_W        (data_W),
        .timeout_W     (timeout_W)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_x(input logic [31:0] instr, input logic [DW-1:0] alu,
                           input logic [DW-1:0] sd, input logic flush);
        instruction_X = instr;
        aluResult_X   = alu;
        storeData_X   = sd;
        flush_X       = flush;
    endtask

    task automatic check_w(input string tag, input logic [31:0] instr,
                           input logic [DW-1:0] data, input logic to);
        check_val({tag, "_instrW"},   instruction_W, instr);
        check_val({tag, "_dataW"},    data_W,        data);
        check_val({tag, "_timeoutW"}, {31'b0, timeout_W}, {31'b0, to});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = '0;

        // reset state
        #1 reset = 1'b1;
        #2;
        check_val("rst_stall", {31'b0, stall_M}, 32'd0);
        check_val("rst_req",   {31'b0, dmem_bus.dmem_req}, 32'd0);
        check_val("rst_we",    {31'b0, dmem_bus.dmem_WE}, 32'd0);
        check_val("rst_addr",  {20'b0, dmem_bus.dmem_addr}, 32'd0);
        check_w("rst", 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // add: pass-through with 1-cycle latency
        drive_x(I_ADD, 32'h2A, 32'h0, 1'b0);
        #2 check_val("add_stall0", {31'b0, stall_M}, 32'd0);
        tick();
        drive_x(NOP_INSTR, 32'h0, 32'h0, 1'b0);
        #2;
        check_val("add_req",    {31'b0, dmem_bus.dmem_req}, 32'd0);
        check_val("add_stall1", {31'b0, stall_M}, 32'd0);
        tick();
        check_w("add", I_ADD, 32'h2A, 1'b0);

        // lw with zero-wait memory
        drive_x(I_LW, 32'h10, 32'h0, 1'b0);
        tick();
        drive_x(NOP_INSTR, 32'h0, 32'h0, 1'b0);
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'hDEAD;
        #2;
        check_val("lw0_req",   {31'b0, dmem_bus.dmem_req}, 32'd1);
        check_val("lw0_we",    {31'b0, dmem_bus.dmem_WE}, 32'd0);
        check_val("lw0_addr",  {20'b0, dmem_bus.dmem_addr}, 32'h010);
        check_val("lw0_stall", {31'b0, stall_M}, 32'd0);
        tick();
        dmem_bus.dmem_ready = 1'b0;
        check_w("lw0", I_LW, 32'hDEAD, 1'b0);

        // sw, memory ready on the 4th request cycle; X holds a waiting add
        drive_x(I_SW, 32'h20, 32'h55, 1'b0);
        tick();
        drive_x(I_ADD, 32'h77, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #2;
            check_val($sformatf("sw_req_%0d", i),   {31'b0, dmem_bus.dmem_req}, 32'd1);
            check_val($sformatf("sw_we_%0d", i),    {31'b0, dmem_bus.dmem_WE}, 32'd1);
            check_val($sformatf("sw_stall_%0d", i), {31'b0, stall_M}, 32'd1);
            check_val($sformatf("sw_addr_%0d", i),  {20'b0, dmem_bus.dmem_addr}, 32'h020);
            tick();
            check_w($sformatf("sw_bubble_%0d", i), 32'd0, 32'd0, 1'b0);
        end
        dmem_bus.dmem_ready = 1'b1;
        #2;
        check_val("sw_req_3",   {31'b0, dmem_bus.dmem_req}, 32'd1);
        check_val("sw_we_3",    {31'b0, dmem_bus.dmem_WE}, 32'd1);
        check_val("sw_stall_3", {31'b0, stall_M}, 32'd0);
        check_val("sw_wdata",   dmem_bus.dmem_wdata, 32'h55);
        tick();
        dmem_bus.dmem_ready = 1'b0;
        drive_x(NOP_INSTR, 32'h0, 32'h0, 1'b0);
        check_w("sw_done", I_SW, 32'h20, 1'b0);
        #2 check_val("sw_next_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        tick();
        check_w("sw_held_add", I_ADD, 32'h77, 1'b0);

        // lw that never gets ready: aborted on the 16th request cycle
        drive_x(I_LW, 32'h30, 32'h0, 1'b0);
        tick();
        drive_x(I_ADD, 32'h99, 32'h0, 1'b0);
        for (int i = 1; i <= MW; i++) begin
            #2;
            check_val($sformatf("to_stall_%0d", i), {31'b0, stall_M}, 32'd1);
            tick();
            check_val($sformatf("to_bubble_%0d", i), instruction_W, 32'd0);
        end
        #2;
        check_val("to_stall_16", {31'b0, stall_M}, 32'd0);
        check_val("to_req_16",   {31'b0, dmem_bus.dmem_req}, 32'd1);
        tick();
        drive_x(NOP_INSTR, 32'h0, 32'h0, 1'b0);
        check_w("to_abort", I_LW, 32'h0, 1'b1);
        #2 check_val("to_after_stall", {31'b0, stall_M}, 32'd0);
        tick();
        check_w("to_after_add", I_ADD, 32'h99, 1'b0);

        // flush while moving: M becomes nop
        drive_x(I_LW, 32'h40, 32'h0, 1'b1);
        tick();
        drive_x(NOP_INSTR, 32'h0, 32'h0, 1'b0);
        #2 check_val("flush_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        tick();
        check_val("flush_w", instruction_W, 32'd0);

        // flush during a stall is ignored
        drive_x(I_LW, 32'h40, 32'h0, 1'b0);
        tick();
        drive_x(I_ADD, 32'h11, 32'h0, 1'b1);
        #2 check_val("fst_stall", {31'b0, stall_M}, 32'd1);
        tick();
        #2;
        check_val("fst_req",  {31'b0, dmem_bus.dmem_req}, 32'd1);
        check_val("fst_addr", {20'b0, dmem_bus.dmem_addr}, 32'h040);
        tick();
        drive_x(NOP_INSTR, 32'h0, 32'h0, 1'b0);
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'hBEEF;
        #2 check_val("fst_stall_rel", {31'b0, stall_M}, 32'd0);
        tick();
        dmem_bus.dmem_ready = 1'b0;
        check_w("fst_done", I_LW, 32'hBEEF, 1'b0);

        // asynchronous reset in the middle of a wait
        drive_x(I_SW, 32'h50, 32'h66, 1'b0);
        tick();
        drive_x(NOP_INSTR, 32'h0, 32'h0, 1'b0);
        tick();
        #2 check_val("rw_stall_pre", {31'b0, stall_M}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check_val("rw_req",   {31'b0, dmem_bus.dmem_req}, 32'd0);
        check_val("rw_we",    {31'b0, dmem_bus.dmem_WE}, 32'd0);
        check_val("rw_stall", {31'b0, stall_M}, 32'd0);
        check_val("rw_addr",  {20'b0, dmem_bus.dmem_addr}, 32'd0);
        check_val("rw_wdata", dmem_bus.dmem_wdata, 32'd0);
        check_w("rw", 32'd0, 32'd0, 1'b0);
        tick();
        reset = 1'b0;
        drive_x(I_ADD, 32'h5A, 32'h0, 1'b0);
        tick();
        drive_x(NOP_INSTR, 32'h0, 32'h0, 1'b0);
        #2 check_val("rw_add_stall", {31'b0, stall_M}, 32'd0);
        tick();
        check_w("rw_add", I_ADD, 32'h5A, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
